// File: rtl/ascon_output_unpacker.sv
// ascon_output_unpacker: buffers ASCON core output blocks in a small FIFO,
// unpacks each block into WORD_WIDTH words behind a valid/ready handshake,
// and latches the final tag.
// Optional build macro ASCON_UNPACK_TAG_CHECK_EN adds the decrypt tag comparator;
// without it auth_valid_o/auth_ok_o are tied low and exp_tag_i is unused.
module ascon_output_unpacker #(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 128,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         decrypt_i,
  input  logic [BLOCK_WIDTH-1:0]       blk_data_i,
  input  logic                         blk_valid_i,
  input  logic [TAG_WIDTH-1:0]         tag_i,
  input  logic                         tag_valid_i,
  input  logic [TAG_WIDTH-1:0]         exp_tag_i,
  output logic [WORD_WIDTH-1:0]        word_o,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic                         word_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic [TAG_WIDTH-1:0]         tag_o,
  output logic                         tag_ready_o,
  output logic                         auth_valid_o,
  output logic                         auth_ok_o
);

  localparam int unsigned WORDS = BLOCK_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [BLOCK_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   overflow_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   tag_ready_q;

  logic [WORD_WIDTH-1:0]  head_words [WORDS];
  logic                   has_data;
  logic                   xfer;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Handshake decode: a pop frees a slot for a same-cycle push; clear wins over both
  always_comb begin
    has_data = (count_q != '0);
    xfer     = has_data && word_ready_i;
    pop      = xfer && (idx_q == IDX_LAST);
    push     = blk_valid_i && !clear_i && ((count_q != CNT_FULL) || pop);
    drop     = blk_valid_i && !clear_i && !push;
  end

  // Block storage; contents are only observed through word_o while count is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= blk_data_i;
    end
  end

  // Slice the head block into words, word 0 being the least-significant slice
  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      head_words[k] = mem[rd_ptr][k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // FIFO pointers, occupancy, word index and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (xfer) begin
        idx_q <= pop ? '0 : idx_q + IDX_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Tag capture; a later pulse overwrites the held tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      tag_ready_q <= 1'b0;
    end else if (clear_i) begin
      tag_q       <= '0;
      tag_ready_q <= 1'b0;
    end else if (tag_valid_i) begin
      tag_q       <= tag_i;
      tag_ready_q <= 1'b1;
    end
  end

`ifdef ASCON_UNPACK_TAG_CHECK_EN
  logic auth_valid_q;
  logic auth_ok_q;

  // Decrypt tag check; result held until clear, re-evaluated by later decrypt tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auth_valid_q <= 1'b0;
      auth_ok_q    <= 1'b0;
    end else if (clear_i) begin
      auth_valid_q <= 1'b0;
      auth_ok_q    <= 1'b0;
    end else if (tag_valid_i && decrypt_i) begin
      auth_valid_q <= 1'b1;
      auth_ok_q    <= (tag_i == exp_tag_i);
    end
  end

  assign auth_valid_o = auth_valid_q;
  assign auth_ok_o    = auth_ok_q;
`else
  logic unused_tag_check;

  // No comparator in this build; expected tag and direction are ignored
  assign unused_tag_check = ^{exp_tag_i, decrypt_i};
  assign auth_valid_o     = 1'b0;
  assign auth_ok_o        = 1'b0;
`endif

  // Output view; word_o is forced to zero while nothing is buffered
  assign word_valid_o = has_data;
  assign word_o       = has_data ? head_words[idx_q] : '0;
  assign word_last_o  = has_data && (idx_q == IDX_LAST);
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign tag_o        = tag_q;
  assign tag_ready_o  = tag_ready_q;

endmodule

// File: tb/tb_ascon_output_unpacker.sv
// Directed bench for ascon_output_unpacker (BLOCK 128, WORD 32, TAG 128, DEPTH 4).
module tb_ascon_output_unpacker;

`ifdef ASCON_UNPACK_TAG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear_i;
  logic         decrypt_i;
  logic [127:0] blk_data_i;
  logic         blk_valid_i;
  logic [127:0] tag_i;
  logic         tag_valid_i;
  logic [127:0] exp_tag_i;
  logic [31:0]  word_o;
  logic         word_valid_o;
  logic         word_ready_i;
  logic         word_last_o;
  logic [2:0]   count_o;
  logic         overflow_o;
  logic [127:0] tag_o;
  logic         tag_ready_o;
  logic         auth_valid_o;
  logic         auth_ok_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ascon_output_unpacker #(
    .BLOCK_WIDTH(128), .WORD_WIDTH(32), .TAG_WIDTH(128), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .decrypt_i(decrypt_i),
    .blk_data_i(blk_data_i), .blk_valid_i(blk_valid_i),
    .tag_i(tag_i), .tag_valid_i(tag_valid_i), .exp_tag_i(exp_tag_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_last_o(word_last_o), .count_o(count_o), .overflow_o(overflow_o),
    .tag_o(tag_o), .tag_ready_o(tag_ready_o),
    .auth_valid_o(auth_valid_o), .auth_ok_o(auth_ok_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Block whose word k reads 0xA5_<id>_00_<k>
  function automatic logic [127:0] mk_blk(input logic [7:0] id);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = {8'hA5, id, 8'h00, 8'(k)};
    return b;
  endfunction

  // Expects word_ready_i=1 and the block at the head with index 0
  task automatic drain_check(input string tag, input logic [7:0] id);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_valid"}, word_valid_o, 1'b1);
      check({tag, "_word"}, word_o, {8'hA5, id, 8'h00, 8'(k)});
      check({tag, "_last"}, word_last_o, k == 3);
      step();
    end
  endtask

  logic [31:0] exp1 [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [31:0] exp2 [6] = '{32'h11111111, 32'h22222222, 32'h22222222,
                            32'h22222222, 32'h33333333, 32'h44444444};
  logic        rdy2 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; decrypt_i = 1'b0; blk_data_i = '0; blk_valid_i = 1'b0;
    tag_i = '0; tag_valid_i = 1'b0; exp_tag_i = '0; word_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count_o, 0);
    check("rst_valid", word_valid_o, 0);
    check("rst_word", word_o, 0);
    check("rst_last", word_last_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_tag_ready", tag_ready_o, 0);
    check("rst_auth_valid", auth_valid_o, 0);
    rst_n = 1'b1;
    step();

    // Single block, consumer always ready
    word_ready_i = 1'b1;
    blk_data_i = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    blk_valid_i = 1'b1;
    step();
    blk_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", word_valid_o, 1);
      check("t1_word", word_o, exp1[k]);
      check("t1_last", word_last_o, k == 3);
      step();
    end
    check("t1_count_end", count_o, 0);
    check("t1_valid_end", word_valid_o, 0);

    // Backpressure: ready 1,0,0,1 then 1,1
    word_ready_i = 1'b0;
    blk_data_i = 128'h44444444_33333333_22222222_11111111;
    blk_valid_i = 1'b1;
    step();
    blk_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      word_ready_i = rdy2[i];
      check("t2_word", word_o, exp2[i]);
      step();
    end
    check("t2_count_end", count_o, 0);

    // Overflow: five pushes with no drain
    word_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      blk_data_i = mk_blk(8'(8'h10 + i));
      blk_valid_i = 1'b1;
      step();
    end
    blk_valid_i = 1'b0;
    check("t3_count_full", count_o, 4);
    check("t3_ovf", overflow_o, 1);
    word_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) drain_check("t3_drain", 8'(8'h10 + i));
    check("t3_count_end", count_o, 0);
    check("t3_ovf_sticky", overflow_o, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("t3_ovf_cleared", overflow_o, 0);

    // Tags: non-decrypt, decrypt match, decrypt mismatch in bit 0
    tag_i = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    exp_tag_i = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    decrypt_i = 1'b0; tag_valid_i = 1'b1;
    step();
    tag_valid_i = 1'b0;
    check("t5_tag", tag_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("t5_tag_ready", tag_ready_o, 1);
    check("t5_enc_auth_valid", auth_valid_o, 0);
    check("t5_enc_auth_ok", auth_ok_o, 0);
    decrypt_i = 1'b1; tag_valid_i = 1'b1;
    step();
    tag_valid_i = 1'b0;
    check("t5_match_valid", auth_valid_o, CHK);
    check("t5_match_ok", auth_ok_o, CHK);
    tag_i = 128'h00112233_44556677_8899AABB_CCDDEEFE;
    tag_valid_i = 1'b1;
    step();
    tag_valid_i = 1'b0; decrypt_i = 1'b0;
    check("t5_flip_tag", tag_o, 128'h00112233_44556677_8899AABB_CCDDEEFE);
    check("t5_flip_valid", auth_valid_o, CHK);
    check("t5_flip_ok", auth_ok_o, 0);

    // Full FIFO, last-word pop coincident with a push
    word_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      blk_data_i = mk_blk(8'(8'h20 + i));
      blk_valid_i = 1'b1;
      step();
    end
    blk_valid_i = 1'b0;
    word_ready_i = 1'b1;
    repeat (3) step();
    check("t4_last_before", word_last_o, 1);
    blk_data_i = mk_blk(8'h24);
    blk_valid_i = 1'b1;
    step();
    blk_valid_i = 1'b0;
    check("t4_count", count_o, 4);
    check("t4_ovf", overflow_o, 0);
    for (int i = 1; i < 5; i++) drain_check("t4_drain", 8'(8'h20 + i));
    check("t4_count_end", count_o, 0);

    // Clear at index 2 with a coincident block and tag
    word_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      blk_data_i = mk_blk(8'(8'h30 + i));
      blk_valid_i = 1'b1;
      step();
    end
    blk_valid_i = 1'b0;
    word_ready_i = 1'b1;
    repeat (2) step();
    check("t6_word_idx2", word_o, 32'hA5300002);
    word_ready_i = 1'b0;
    clear_i = 1'b1; blk_data_i = mk_blk(8'h32); blk_valid_i = 1'b1;
    tag_i = 128'hDEAD; tag_valid_i = 1'b1; decrypt_i = 1'b1;
    step();
    clear_i = 1'b0; blk_valid_i = 1'b0; tag_valid_i = 1'b0; decrypt_i = 1'b0;
    check("t6_count", count_o, 0);
    check("t6_valid", word_valid_o, 0);
    check("t6_word", word_o, 0);
    check("t6_ovf", overflow_o, 0);
    check("t6_tag_ready", tag_ready_o, 0);
    check("t6_auth_valid", auth_valid_o, 0);
    check("t6_auth_ok", auth_ok_o, 0);
    step();
    check("t6_count_later", count_o, 0);
    blk_data_i = mk_blk(8'h40); blk_valid_i = 1'b1;
    step();
    blk_valid_i = 1'b0;
    check("t6_restart_word", word_o, 32'hA5400000);

    // Reset while the head is partially drained
    word_ready_i = 1'b1;
    step();
    check("t7_word1", word_o, 32'hA5400001);
    rst_n = 1'b0;
    #1;
    check("t7_rst_count", count_o, 0);
    check("t7_rst_valid", word_valid_o, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t7_after_valid", word_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_output_unpacker.md
Name: ascon_output_unpacker

Overview:
Downstream stage of the ASCON AEAD core. The core's data and tag outputs are single-cycle valid pulses with no backpressure.
- Data path: buffers output blocks in a small FIFO and unpacks each block into bus-width words behind a valid/ready handshake.
- Tag path: latches the final tag and, optionally, checks it against an expected tag for decryption.
- Sits between the core and the subsystem register/stream interface.

Parameters:
BLOCK_WIDTH, 128, width of one core output block; must be a multiple of WORD_WIDTH
WORD_WIDTH, 32, width of the unpacked output word
TAG_WIDTH, 128, width of the authentication tag
DEPTH, 4, FIFO depth in blocks; power of two, at least 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clear_i  input  1  synchronous flush of FIFO, index, flags and tag state
decrypt_i  input  1  current operation is decryption; sampled on tag_valid_i
blk_data_i  input  BLOCK_WIDTH  output block from the core
blk_valid_i  input  1  one-cycle pulse; blk_data_i is valid
tag_i  input  TAG_WIDTH  tag from the core
tag_valid_i  input  1  one-cycle pulse; tag_i is valid
exp_tag_i  input  TAG_WIDTH  expected tag for decrypt check
word_o  output  WORD_WIDTH  current unpacked word
word_valid_o  output  1  word_o is valid
word_ready_i  input  1  consumer accepts word_o
word_last_o  output  1  word_o is the last word of its block
count_o  output  $clog2(DEPTH+1)  number of blocks stored, including the partially drained head
overflow_o  output  1  sticky; a block was dropped because the FIFO was full
tag_o  output  TAG_WIDTH  latched tag
tag_ready_o  output  1  sticky; tag_o holds a valid tag
auth_valid_o  output  1  sticky; authentication result available
auth_ok_o  output  1  computed tag equals exp_tag_i

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous active-low and resets everything.
- Reset values: all outputs 0 (word_o, tag_o, count_o, flags). FIFO pointers and word index are 0.
- WORDS = BLOCK_WIDTH/WORD_WIDTH.
- Word order: word k = blk_data_i[k*WORD_WIDTH +: WORD_WIDTH], so word 0 is the least-significant slice.
- Push:
  - A blk_valid_i pulse writes the block at the write pointer when count_o < DEPTH, or when a pop happens in the same cycle.
  - If the FIFO is full and no pop occurs, the block is dropped and overflow_o is set. It stays set until clear_i.
- Latency: block pushed in cycle t → word_valid_o=1 with word 0 in cycle t+1. word_o and word_last_o are selected from registered storage; no combinational path from blk_data_i.
- Output handshake:
  - word_valid_o = (count_o != 0).
  - A word transfers when word_valid_o && word_ready_i. On transfer the index increments.
  - On transfer with index == WORDS-1: index returns to 0, the head block is popped, and the read pointer advances.
  - word_last_o = word_valid_o && index == WORDS-1.
- Stability: word_o holds stable while word_valid_o=1 and word_ready_i=0.
- Pointer wrap: read and write pointers wrap modulo DEPTH. count_o changes by +1, -1, or 0 for a simultaneous push and pop.
- Tag capture: on tag_valid_i, tag_o ← tag_i and tag_ready_o ← 1 in the next cycle. A second tag pulse before clear_i overwrites tag_o.
- clear_i:
  - Next cycle: count_o=0, index=0, overflow_o=0, tag_ready_o=0, auth_valid_o=0, auth_ok_o=0.
  - Overrides a blk_valid_i or tag_valid_i in the same cycle; the pulse is discarded.
- Reset mid-block: a partially drained head is discarded with no further words emitted.

Optional Feature:
Macro ASCON_UNPACK_TAG_CHECK_EN.
- Defined: on tag_valid_i with decrypt_i=1, the next cycle sets auth_valid_o=1 and auth_ok_o=(tag_i==exp_tag_i), compared over all TAG_WIDTH bits.
  - Both outputs are held until clear_i.
  - With decrypt_i=0, auth_valid_o and auth_ok_o stay 0.
  - A later tag pulse re-evaluates both outputs.
- Undefined: no comparator is built, auth_valid_o and auth_ok_o are tied to 0, and exp_tag_i is unused. The port list is identical in both builds.

Test Plan:
- Single block 0x0F0E0D0C_0B0A0908_07060504_03020100, word_ready_i=1 → four words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in consecutive cycles; first word one cycle after the pulse; word_last_o=1 on the 4th word only; count_o returns to 0.
- Backpressure: word_ready_i toggles 1,0,0,1 → word_o stable during stalls; no word duplicated or lost.
- Full: 5 pulses with word_ready_i=0 and DEPTH=4 → count_o=4, overflow_o=1, and the 5th block is absent on drain.
- Simultaneous push and pop: FIFO full and a last-word transfer in the same cycle as blk_valid_i → block accepted, count_o stays 4, overflow_o stays 0.
- Tag check (macro on), decrypt_i=1:
  - tag_i == exp_tag_i → auth_valid_o=1, auth_ok_o=1.
  - Repeat with bit 0 flipped → auth_ok_o=0.
  - decrypt_i=0 → auth_valid_o stays 0.
- clear_i asserted mid-block (index=2) with a coincident blk_valid_i → next cycle count_o=0, word_valid_o=0, all flags 0; the coincident block is not stored.
